// File: rtl/if_axi_fetch_pkg.sv
// Shared constants and the fetch FSM state type for the AXI instruction-fetch responder.
package if_axi_fetch_pkg;

  localparam logic [31:0] INST_NOP       = 32'h0000_0013;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_8B    = 3'b011;
  localparam logic [7:0]  AXI_LEN_SINGLE = 8'd0;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_AR   = 2'd1,
    IF_R    = 2'd2
  } if_state_e;

endpackage : if_axi_fetch_pkg

// File: rtl/if_axi_fetch.sv
// Instruction-fetch responder: turns each PC-stage fetch miss into one single-beat
// AXI4 read, buffers the returned instruction, and stalls the pipeline until it hits.
module if_axi_fetch
  import if_axi_fetch_pkg::*;
#(
  parameter int               ADDR_W   = 64,
  parameter int               DATA_W   = 64,
  parameter int               INST_W   = 32,
  parameter int               ID_W     = 4,
  parameter logic [ID_W-1:0]  FETCH_ID = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  output logic [INST_W-1:0] inst_o,
  output logic              stallreq_o,
  output logic              fetch_err_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  output logic [ID_W-1:0]   arid_o,
  output logic [7:0]        arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  input  logic              rvalid_i,
  output logic              rready_o
);

  if_state_e          state, state_next;
  logic [ADDR_W-1:0]  req_pc;
  logic               discard;
  logic               buf_valid;
  logic [ADDR_W-1:0]  buf_pc;
  logic [INST_W-1:0]  buf_inst;

  logic misaligned, hit, issue, ar_hs, r_hs, keep;

  // Every read is a single beat, so RLAST carries no information here.
  logic rlast_unused;
  assign rlast_unused = rlast_i;

  assign misaligned = (pc_i[1:0] != 2'b00);
  assign hit        = buf_valid && (buf_pc == pc_i) && !flush_i;
  assign issue      = (state == IF_IDLE) && ce_i && !hit && !misaligned;
  assign ar_hs      = (state == IF_AR) && arready_i;
  assign r_hs       = (state == IF_R) && rvalid_i && rready_o;
  // A redirect in the handshake cycle makes the returning data stale as well.
  assign keep       = r_hs && !discard && !flush_i;

  assign inst_o     = (ce_i && hit) ? buf_inst : (misaligned ? INST_NOP : '0);
  assign stallreq_o = ce_i && !hit && !misaligned;

  assign arid_o     = FETCH_ID;
  assign arlen_o    = AXI_LEN_SINGLE;
  assign arsize_o   = AXI_SIZE_8B;
  assign arburst_o  = AXI_BURST_INCR;

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IF_IDLE;
    else      state <= state_next;
  end

  // FSM next-state: one outstanding read, walked through AR then R.
  // NOTE: the default assignment comes first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IF_IDLE: if (issue)  state_next = IF_AR;
      IF_AR:   if (ar_hs)  state_next = IF_R;
      IF_R:    if (r_hs)   state_next = IF_IDLE;
      default:             state_next = IF_IDLE;
    endcase
  end

  // AXI request side: address/valid held stable from issue until the AR handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      araddr_o  <= '0;
      arvalid_o <= 1'b0;
      rready_o  <= 1'b0;
      req_pc    <= '0;
    end else begin
      if (issue) begin
        req_pc    <= pc_i;
        araddr_o  <= {pc_i[ADDR_W-1:3], 3'b000};
        arvalid_o <= 1'b1;
      end
      if (ar_hs) begin
        arvalid_o <= 1'b0;
        rready_o  <= 1'b1;
      end
      if (r_hs) rready_o <= 1'b0;
    end
  end

  // Redirect bookkeeping: an in-flight read still completes, but its data is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             discard <= 1'b0;
    else if (r_hs)                        discard <= 1'b0;
    else if (flush_i && state != IF_IDLE) discard <= 1'b1;
  end

  // Instruction buffer and error pulse, written when a non-stale beat returns.
  // NOTE: the buffer is reset too, so inst_o and buf_pc are defined from the first cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid   <= 1'b0;
      buf_pc      <= '0;
      buf_inst    <= '0;
      fetch_err_o <= 1'b0;
    end else begin
      fetch_err_o <= (state == IF_IDLE) && ce_i && misaligned;
      if (flush_i)   buf_valid <= 1'b0;
      else if (keep) buf_valid <= 1'b1;
      if (keep) begin
        buf_pc <= req_pc;
        if (rresp_i != AXI_RESP_OKAY) begin
          buf_inst    <= INST_NOP;
          fetch_err_o <= 1'b1;
        end else begin
          buf_inst <= req_pc[2] ? rdata_i[INST_W +: INST_W] : rdata_i[INST_W-1:0];
        end
      end
    end
  end

endmodule : if_axi_fetch
